cdb_arbiter: RTL and testbench

- Shares the single Common Data Bus between all result producers: the load/store unit's load-result port, the ALU and the multiplier/divider.
- Each producer presents a result over a valid/ready handshake.
- The arbiter grants one producer per cycle and registers the winner's tag and data.
- It broadcasts the registered result one cycle later to every reservation station, the register file and the load/store reservation stations.
- On a branch mispredict it squashes speculative results, both waiting and already registered.

---
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one producer per cycle, registers and broadcasts its result.
// Define CDB_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 first).
module cdb_arbiter #(
  parameter int NUM_REQ           = 3,
  parameter int BW_TAG            = 4,
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_CNT            = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  input  logic [NUM_REQ*BW_TAG-1:0]              i_req_tag,
  input  logic [NUM_REQ*BW_PROCESSOR_DATA-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]                     i_req_spec,
  input  logic                                   i_branch_valid,
  input  logic                                   i_branch_correct_prediction,
  output logic                                   o_cdb_valid,
  output logic [BW_TAG-1:0]                      o_cdb_tag,
  output logic [BW_PROCESSOR_DATA-1:0]           o_cdb_data,
  output logic                                   o_cdb_spec,
  output logic [BW_CNT-1:0]                      o_bcast_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                         mispredict_s;
  logic                         correct_s;
  logic [NUM_REQ-1:0]           kill_s;
  logic [NUM_REQ-1:0]           elig_s;
  logic [NUM_REQ-1:0]           grant_s;
  logic                         grant_any_s;
  logic [IDX_W-1:0]             grant_idx_s;

  logic                         cdb_valid_q, cdb_valid_d;
  logic [BW_TAG-1:0]            cdb_tag_q, cdb_tag_d;
  logic [BW_PROCESSOR_DATA-1:0] cdb_data_q, cdb_data_d;
  logic                         cdb_spec_q, cdb_spec_d;
  logic [BW_CNT-1:0]            bcast_cnt_q, bcast_cnt_d;

  assign mispredict_s = i_branch_valid & ~i_branch_correct_prediction;
  assign correct_s    = i_branch_valid & i_branch_correct_prediction;
  // A mispredict makes every speculative requester ineligible in the same cycle.
  assign kill_s       = i_req_spec & {NUM_REQ{mispredict_s}};
  assign elig_s       = i_req_valid & ~kill_s;

`ifdef CDB_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any_s && elig_s[(int'(ptr_q) + i) % NUM_REQ]) begin
        grant_any_s = 1'b1;
        grant_idx_s = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Pointer moves past the winner; it stays put when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any_s) begin
      ptr_d = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : grant_idx_s + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the lowest eligible index wins, so loads go first.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any_s && elig_s[i]) begin
        grant_any_s = 1'b1;
        grant_idx_s = IDX_W'(i);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end
`endif

  // One-hot ready, suppressed while reset is held.
  always_comb begin
    grant_s = '0;
    if (grant_any_s && !rst) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign o_req_ready = grant_s;

  // Next broadcast: load the winner, otherwise drop valid and hold tag/data.
  always_comb begin
    cdb_valid_d = grant_any_s;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    bcast_cnt_d = bcast_cnt_q;
    if (grant_any_s) begin
      cdb_tag_d   = i_req_tag[grant_idx_s*BW_TAG +: BW_TAG];
      cdb_data_d  = i_req_data[grant_idx_s*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
      cdb_spec_d  = i_req_spec[grant_idx_s] & ~correct_s;
      bcast_cnt_d = bcast_cnt_q + BW_CNT'(1);
    end else begin
      // Any resolution of the single branch level ends speculation of the held result.
      cdb_spec_d  = cdb_spec_q & ~i_branch_valid;
    end
  end

  // Broadcast register and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_spec_q  <= 1'b0;
      bcast_cnt_q <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_spec_q  <= cdb_spec_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign o_cdb_valid = cdb_valid_q;
  assign o_cdb_tag   = cdb_tag_q;
  assign o_cdb_data  = cdb_data_q;
  assign o_cdb_spec  = cdb_spec_q;
  assign o_bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference model plus directed vectors with literal expectations.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int CW = 4;
`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_spec = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            br_valid = 1'b0;
  logic            br_ok = 1'b0;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic            cdb_spec;
  logic [CW-1:0]   bcast_cnt;

  cdb_arbiter #(.NUM_REQ(N), .BW_TAG(TW), .BW_PROCESSOR_DATA(DW), .BW_CNT(CW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_tag(req_tag), .i_req_data(req_data), .i_req_spec(req_spec),
    .i_branch_valid(br_valid), .i_branch_correct_prediction(br_ok),
    .o_cdb_valid(cdb_valid), .o_cdb_tag(cdb_tag), .o_cdb_data(cdb_data),
    .o_cdb_spec(cdb_spec), .o_bcast_cnt(bcast_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner by the rules: first eligible producer scanning from start; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] sp,
                              input logic bv, input logic bc, input int start);
    for (int off = 0; off < N; off++) begin
      int k = (start + off) % N;
      if (v[k] && !(bv && !bc && sp[k])) return k;
    end
    return -1;
  endfunction

  logic          m_valid = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_spec = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  int            m_ptr = 0;
  int            m_grant;

  assign m_grant = pick(req_valid, req_spec, br_valid, br_ok, RR ? m_ptr : 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_tag <= '0; m_data <= '0; m_spec <= 1'b0; m_cnt <= '0; m_ptr <= 0;
    end else if (m_grant >= 0) begin
      m_valid <= 1'b1;
      m_tag   <= req_tag[m_grant*TW +: TW];
      m_data  <= req_data[m_grant*DW +: DW];
      m_spec  <= req_spec[m_grant] && !(br_valid && br_ok);
      m_cnt   <= m_cnt + 4'd1;
      m_ptr   <= (m_grant + 1) % N;
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    #1;
    chk("ready", req_ready, (rst || m_grant < 0) ? 3'b000 : (3'b001 << m_grant));
    chk("cdb_valid", cdb_valid, m_valid);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("cdb_data", cdb_data, m_data);
    chk("bcast_cnt", bcast_cnt, m_cnt);
    if (m_valid) chk("cdb_spec", cdb_spec, m_spec);
  end

  task automatic setp(input int k, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_tag[k*TW +: TW]  = t;
    req_data[k*DW +: DW] = d;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] sp, input logic bv, input logic bc);
    req_valid = v; req_spec = sp; br_valid = bv; br_ok = bc;
  endtask

  logic [N-1:0] exp_cont [6];

  initial begin
    if (RR) exp_cont = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    else    exp_cont = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_cnt", bcast_cnt, 4'h0);
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_tag", cdb_tag, 4'h0);
    @(negedge clk); rst = 1'b0;

    // Single request from producer 1.
    @(negedge clk); setp(1, 4'h5, 32'hDEADBEEF); drive(3'b010, 3'b000, 1'b0, 1'b0);
    #1 chk("single_ready", req_ready, 3'b010);
    @(negedge clk); drive(3'b000, 3'b000, 1'b0, 1'b0);
    #1;
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_tag", cdb_tag, 4'h5);
    chk("single_data", cdb_data, 32'hDEADBEEF);
    chk("single_cnt", bcast_cnt, 4'h1);

    // Asynchronous reset while a broadcast is on the bus.
    setp(0, 4'h3, 32'h0000_0011);
    @(negedge clk); drive(3'b001, 3'b000, 1'b0, 1'b0);
    @(negedge clk); drive(3'b000, 3'b000, 1'b0, 1'b0);
    #2 chk("midrst_pre_valid", cdb_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", cdb_valid, 1'b0);
    chk("midrst_cnt", bcast_cnt, 4'h0);

    // Contention: all three hold valid for six cycles.
    setp(0, 4'h1, 32'hA0A0_0000); setp(1, 4'h2, 32'hB1B1_0001); setp(2, 4'h3, 32'hC2C2_0002);
    @(negedge clk); rst = 1'b0; drive(3'b111, 3'b000, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1 chk("contention_ready", req_ready, exp_cont[c]);
    end

    // Mispredict kills speculative producer 2; producer 1 wins.
    setp(1, 4'h7, 32'h7777_0007); setp(2, 4'h9, 32'h9999_0009);
    @(negedge clk); drive(3'b110, 3'b100, 1'b1, 1'b0);
    #1 chk("kill_ready", req_ready, 3'b010);
    @(negedge clk); drive(3'b000, 3'b000, 1'b0, 1'b0);
    #1;
    chk("kill_valid", cdb_valid, 1'b1);
    chk("kill_tag", cdb_tag, 4'h7);
    chk("kill_spec", cdb_spec, 1'b0);

    // Registered speculative result squashed by a mispredict.
    setp(2, 4'hC, 32'hCCCC_000C);
    @(negedge clk); drive(3'b100, 3'b100, 1'b0, 1'b0);
    @(negedge clk); drive(3'b000, 3'b000, 1'b1, 1'b0);
    #1;
    chk("squash_visible", cdb_valid, 1'b1);
    chk("squash_spec", cdb_spec, 1'b1);
    chk("squash_tag", cdb_tag, 4'hC);
    @(negedge clk); drive(3'b000, 3'b000, 1'b0, 1'b0);
    #1;
    chk("squash_valid", cdb_valid, 1'b0);
    chk("squash_cnt", bcast_cnt, 4'h8);

    // Correct prediction masks the incoming speculative bit.
    setp(0, 4'hA, 32'hAAAA_000A); setp(1, 4'hB, 32'hBBBB_000B);
    @(negedge clk); drive(3'b001, 3'b001, 1'b0, 1'b0);
    @(negedge clk); drive(3'b010, 3'b010, 1'b1, 1'b1);
    #1;
    chk("correct_pre_spec", cdb_spec, 1'b1);
    chk("correct_pre_tag", cdb_tag, 4'hA);
    chk("correct_ready", req_ready, 3'b010);
    @(negedge clk); drive(3'b000, 3'b000, 1'b0, 1'b0);
    #1;
    chk("correct_valid", cdb_valid, 1'b1);
    chk("correct_tag", cdb_tag, 4'hB);
    chk("correct_spec", cdb_spec, 1'b0);
    chk("correct_cnt", bcast_cnt, 4'hA);

    // Counter wrap after sixteen grants.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; drive(3'b001, 3'b000, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    #1 chk("cnt_pre_wrap", bcast_cnt, 4'hF);
    @(negedge clk); drive(3'b000, 3'b000, 1'b0, 1'b0);
    #1;
    chk("cnt_wrap", bcast_cnt, 4'h0);
    chk("cnt_wrap_valid", cdb_valid, 1'b1);

    repeat (3) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
